// File: rtl/traffic_gen_mc_if.sv
// NoC local-port bundle between a traffic_gen_mc endpoint and its router.
//   o_transmit : endpoint -> router, injection request
//   i_send     : router -> endpoint, injection grant
//   o_flit     : endpoint -> router, outgoing flit (registered in the endpoint)
//   i_flit     : router -> endpoint, incoming flit
//   o_rec_ack  : endpoint -> router, sink ready
// Signal names are seen from the endpoint; the master modport is the endpoint side.
interface traffic_gen_mc_if #(
  parameter int unsigned FLIT_W = 32
);
  logic              o_transmit;
  logic              i_send;
  logic [FLIT_W-1:0] o_flit;
  logic [FLIT_W-1:0] i_flit;
  logic              o_rec_ack;

  modport master (
    output o_transmit,
    output o_flit,
    output o_rec_ack,
    input  i_send,
    input  i_flit
  );

  modport slave (
    input  o_transmit,
    input  o_flit,
    input  o_rec_ack,
    output i_send,
    output i_flit
  );
endinterface

// File: rtl/traffic_gen_mc.sv
// NoC endpoint traffic generator and sink.
// Generator: builds head/body/tail packets, requests injection (noc.o_transmit), waits for the
// grant (noc.i_send) and then streams PKT_LEN flits back to back on noc.o_flit. Destination is
// fixed, a row-major sweep, or LFSR-random (i_mode). Sink: checks noc.i_flit framing and
// destination, counts complete packets and keeps sticky error flags.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   i_start               : enable injection
//   i_mode                : 0 fixed, 1 sweep, 2 random, 3 as fixed
//   i_dest_x, i_dest_y    : fixed-mode destination
//   noc                   : local-port bundle (master side)
//   o_sent_pkts/rcvd_pkts : packet counters
//   o_err                 : sticky errors, [0] framing, [1] address
//   o_done                : NUM_PKTS packets sent
module traffic_gen_mc #(
  parameter int unsigned FLIT_W     = 32,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned MESH_X     = 4,
  parameter int unsigned MESH_Y     = 4,
  parameter int unsigned MY_X       = 0,
  parameter int unsigned MY_Y       = 0,
  parameter int unsigned BODY_COUNT = 2,
  parameter int unsigned NUM_PKTS   = 1000,
  parameter int unsigned INJ_GAP    = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [ADDR_W-1:0] i_dest_x,
  input  logic [ADDR_W-1:0] i_dest_y,
  traffic_gen_mc_if.master  noc,
  output logic [15:0]       o_sent_pkts,
  output logic [15:0]       o_rcvd_pkts,
  output logic [1:0]        o_err,
  output logic              o_done
);

  localparam int unsigned PktLast = BODY_COUNT + 1;  // index of the tail flit
  localparam int unsigned TypeHi  = FLIT_W - 2;
  localparam int unsigned HdrHi   = FLIT_W - 4;      // {dst_x, dst_y, src_x, src_y}
  localparam int unsigned DyHi    = HdrHi - ADDR_W;
  localparam logic [ADDR_W-1:0] MyX = ADDR_W'(MY_X);
  localparam logic [ADDR_W-1:0] MyY = ADDR_W'(MY_Y);
  localparam logic [1:0] TypHead = 2'b01;
  localparam logic [1:0] TypBody = 2'b10;
  localparam logic [1:0] TypTail = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StSend, StGap} state_e;

  state_e            state_q, state_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [8:0]        idx_q, idx_d;     // index of the flit currently on o_flit
  logic [15:0]       gap_q, gap_d;
  logic [15:0]       sent_q, sent_d;
  logic [15:0]       rcvd_q, rcvd_d;
  logic [15:0]       cyc_q, cyc_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [1:0]        err_q, err_d;
  logic              open_q, open_d;
  logic [ADDR_W-1:0] ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
  logic [ADDR_W-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;

  logic                done;
  logic [15:0]         lfsr_step;
  logic [2*ADDR_W-1:0] sw_first, sw_next;  // {y, x}
  logic [ADDR_W-1:0]   rnd_x, rnd_y;
  logic                unused_flit;

  function automatic logic [FLIT_W-1:0] mk_flit(logic [1:0] typ, logic [4*ADDR_W-1:0] hdr,
                                                logic [15:0] low);
    logic [FLIT_W-1:0] f;
    f                    = '0;
    f[FLIT_W-1]          = 1'b1;
    f[TypeHi -: 2]       = typ;
    f[HdrHi -: 4*ADDR_W] = hdr;
    f[15:0]              = low;
    return f;
  endfunction

  // Row-major step of the sweep pointer, returns {y, x}.
  function automatic logic [2*ADDR_W-1:0] sweep_next(logic [ADDR_W-1:0] x, logic [ADDR_W-1:0] y);
    logic [ADDR_W-1:0] nx, ny;
    nx = x + 1'b1;
    ny = y;
    if (32'(x) + 32'd1 >= MESH_X) begin
      nx = '0;
      ny = (32'(y) + 32'd1 >= MESH_Y) ? '0 : y + 1'b1;
    end
    return {ny, nx};
  endfunction

  assign done      = (NUM_PKTS != 0) && (sent_q == 16'(NUM_PKTS));
  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign sw_first  = sweep_next(ptr_x_q, ptr_y_q);
  // Own node is skipped by stepping once more.
  assign sw_next   = (sw_first == {MyY, MyX}) ?
                     sweep_next(sw_first[ADDR_W-1:0], sw_first[2*ADDR_W-1:ADDR_W]) : sw_first;

  always_comb begin
    rnd_x = lfsr_step[ADDR_W-1:0];
    rnd_y = lfsr_step[2*ADDR_W-1:ADDR_W];
    if (32'(rnd_x) >= MESH_X) rnd_x = rnd_x - ADDR_W'(MESH_X);
    if (32'(rnd_y) >= MESH_Y) rnd_y = rnd_y - ADDR_W'(MESH_Y);
    if (rnd_x == MyX && rnd_y == MyY) begin
      rnd_x = (32'(rnd_x) + 32'd1 >= MESH_X) ? '0 : rnd_x + 1'b1;
    end
  end

  // Generator next state. o_flit is registered, so each flit is built one cycle ahead.
  always_comb begin
    state_d = state_q;
    flit_d  = '0;
    idx_d   = idx_q;
    gap_d   = gap_q;
    sent_d  = sent_q;
    cyc_d   = cyc_q + 16'd1;
    lfsr_d  = lfsr_q;
    ptr_x_d = ptr_x_q;
    ptr_y_d = ptr_y_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    case (state_q)
      StIdle: begin
        if (i_start && !done) begin
          state_d = StReq;
          case (i_mode)
            2'd1: begin
              ptr_x_d = sw_next[ADDR_W-1:0];
              ptr_y_d = sw_next[2*ADDR_W-1:ADDR_W];
              dst_x_d = sw_next[ADDR_W-1:0];
              dst_y_d = sw_next[2*ADDR_W-1:ADDR_W];
            end
            2'd2: begin
              lfsr_d  = lfsr_step;
              dst_x_d = rnd_x;
              dst_y_d = rnd_y;
            end
            default: begin
              dst_x_d = i_dest_x;
              dst_y_d = i_dest_y;
            end
          endcase
        end
      end
      StReq: begin
        if (!i_start) begin
          state_d = StIdle;
        end else if (noc.i_send) begin
          state_d = StSend;
          idx_d   = '0;
          flit_d  = mk_flit(TypHead, {dst_x_q, dst_y_q, MyX, MyY}, sent_q);
        end
      end
      StSend: begin
        if (idx_q == 9'(PktLast)) begin
          sent_d  = sent_q + 16'd1;
          state_d = (INJ_GAP > 0) ? StGap : StIdle;
          gap_d   = 16'(INJ_GAP - 1);
        end else begin
          idx_d = idx_q + 9'd1;
          if (idx_q == 9'(PktLast - 1)) begin
            flit_d = mk_flit(TypTail, '0, cyc_q + 16'd1);  // counter value while tail is out
          end else begin
            flit_d = mk_flit(TypBody, '0, {sent_q[7:0], idx_q[7:0]});  // body k = flit k+1
          end
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sink: independent of the generator.
  always_comb begin
    err_d  = err_q;
    open_d = open_q;
    rcvd_d = rcvd_q;
    if (noc.i_flit[FLIT_W-1]) begin
      case (noc.i_flit[TypeHi -: 2])
        TypHead: begin
          if (open_q) err_d[0] = 1'b1;
          open_d = 1'b1;
          if (noc.i_flit[HdrHi -: ADDR_W] != MyX || noc.i_flit[DyHi -: ADDR_W] != MyY) begin
            err_d[1] = 1'b1;
          end
        end
        TypBody: begin
          if (!open_q) err_d[0] = 1'b1;
        end
        TypTail: begin
          if (!open_q) begin
            err_d[0] = 1'b1;
          end else begin
            open_d = 1'b0;
            rcvd_d = rcvd_q + 16'd1;
          end
        end
        default: err_d[0] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      flit_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      sent_q  <= '0;
      rcvd_q  <= '0;
      cyc_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      err_q   <= '0;
      open_q  <= 1'b0;
      ptr_x_q <= '0;
      ptr_y_q <= '0;
      dst_x_q <= '0;
      dst_y_q <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      sent_q  <= sent_d;
      rcvd_q  <= rcvd_d;
      cyc_q   <= cyc_d;
      lfsr_q  <= lfsr_d;
      err_q   <= err_d;
      open_q  <= open_d;
      ptr_x_q <= ptr_x_d;
      ptr_y_q <= ptr_y_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
    end
  end

  assign noc.o_transmit = (state_q == StReq);
  assign noc.o_flit     = flit_q;
  assign noc.o_rec_ack  = 1'b1;  // the sink never stalls
  assign o_sent_pkts    = sent_q;
  assign o_rcvd_pkts    = rcvd_q;
  assign o_err          = err_q;
  assign o_done         = done;
  assign unused_flit    = ^noc.i_flit;

endmodule

// File: tb/tb_traffic_gen_mc.sv
module tb_traffic_gen_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [1:0]  dx, dy;
  logic [15:0] sent, rcvd, sent_l, rcvd_l;
  logic [1:0]  err, err_l;
  logic        done, done_l;
  logic [15:0] tb_cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  // Reference free-running cycle counter for tail timestamps.
  always @(posedge clk) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 16'd1;
  end

  traffic_gen_mc_if #(.FLIT_W(32)) noc_if ();
  traffic_gen_mc_if #(.FLIT_W(32)) noc_lim ();

  traffic_gen_mc #(.NUM_PKTS(0)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (start),
    .i_mode      (mode),
    .i_dest_x    (dx),
    .i_dest_y    (dy),
    .noc         (noc_if),
    .o_sent_pkts (sent),
    .o_rcvd_pkts (rcvd),
    .o_err       (err),
    .o_done      (done)
  );

  traffic_gen_mc #(.NUM_PKTS(2)) u_dut_lim (
    .clk         (clk),
    .reset       (reset),
    .i_start     (start),
    .i_mode      (mode),
    .i_dest_x    (dx),
    .i_dest_y    (dy),
    .noc         (noc_lim),
    .o_sent_pkts (sent_l),
    .o_rcvd_pkts (rcvd_l),
    .o_err       (err_l),
    .o_done      (done_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_send(input logic v);
    noc_if.i_send  = v;
    noc_lim.i_send = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance until the next head flit is on o_flit, bounded.
  task automatic wait_head(input string tag, output logic [31:0] f);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = (noc_if.o_flit[31:29] == 3'b101);
    end
    f = noc_if.o_flit;
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] f;
    logic [15:0] l;
    logic [1:0]  ex, ey;
    int          idx;
    int          self_hits;

    reset = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    dx    = 2'd0;
    dy    = 2'd0;
    set_send(1'b0);
    noc_if.i_flit  = '0;
    noc_lim.i_flit = '0;
    tick();
    tick();

    // Reset state
    check_eq("rst_flit", noc_if.o_flit, 32'h0);
    check_eq("rst_transmit", 32'(noc_if.o_transmit), 32'd0);
    check_eq("rst_rec_ack", 32'(noc_if.o_rec_ack), 32'd1);
    check_eq("rst_sent", 32'(sent), 32'd0);
    check_eq("rst_rcvd", 32'(rcvd), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_done", 32'(done_l), 32'd0);
    reset = 1'b0;

    // Fixed destination (3,3), grant tied high
    mode = 2'd0; dx = 2'd3; dy = 2'd3;
    set_send(1'b1);
    start = 1'b1;
    tick();
    check_eq("fix_transmit", 32'(noc_if.o_transmit), 32'd1);
    check_eq("fix_req_flit", noc_if.o_flit, 32'h0);
    tick();
    check_eq("fix_head0", noc_if.o_flit, 32'hBE00_0000);
    tick();
    check_eq("fix_body0_0", noc_if.o_flit, 32'hC000_0000);
    tick();
    check_eq("fix_body0_1", noc_if.o_flit, 32'hC000_0001);
    tick();
    check_eq("fix_tail0", noc_if.o_flit, {16'hE000, tb_cyc});
    tick();
    check_eq("fix_sent1", 32'(sent), 32'd1);
    check_eq("fix_idle_flit", noc_if.o_flit, 32'h0);
    check_eq("fix_done_early", 32'(done_l), 32'd0);
    wait_head("fix_head1", f);
    check_eq("fix_head1", f, 32'hBE00_0001);
    tick();
    check_eq("fix_body1_0", noc_if.o_flit, 32'hC000_0100);
    tick();
    check_eq("fix_body1_1", noc_if.o_flit, 32'hC000_0101);
    tick();
    check_eq("fix_tail1", noc_if.o_flit, {16'hE000, tb_cyc});
    tick();
    check_eq("fix_sent2", 32'(sent_l), 32'd2);
    check_eq("fix_done", 32'(done_l), 32'd1);
    check_eq("fix_unlim_done", 32'(done), 32'd0);
    tick(); tick(); tick();
    check_eq("fix_done_blocks", 32'(noc_lim.o_transmit), 32'd0);
    check_eq("fix_done_sticky", 32'(done_l), 32'd1);

    // Row-major sweep from (0,0), own node skipped
    do_reset();
    mode  = 2'd1;
    start = 1'b1;
    for (int p = 0; p < 17; p++) begin
      idx = (p % 15) + 1;
      ex  = 2'(idx % 4);
      ey  = 2'(idx / 4);
      wait_head("swp", f);
      check_eq($sformatf("swp_dst%0d", p), 32'(f[28:25]), 32'({ex, ey}));
    end

    // LFSR-random destinations against a reference LFSR
    do_reset();
    mode      = 2'd2;
    start     = 1'b1;
    l         = 16'hACE1;
    self_hits = 0;
    for (int p = 0; p < 100; p++) begin
      l  = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      ex = l[1:0];
      ey = l[3:2];
      if (ex == 2'd0 && ey == 2'd0) ex = 2'd1;
      wait_head("rnd", f);
      if (f[28:25] == 4'h0) self_hits++;
      check_eq($sformatf("rnd_dst%0d", p), 32'(f[28:25]), 32'({ex, ey}));
    end
    check_eq("rnd_self_hits", 32'(self_hits), 32'd0);

    // Grant withheld, then start dropped in REQ
    do_reset();
    mode = 2'd0; dx = 2'd1; dy = 2'd2;
    set_send(1'b0);
    start = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq($sformatf("hold_transmit%0d", c), 32'(noc_if.o_transmit), 32'd1);
      check_eq($sformatf("hold_flit%0d", c), noc_if.o_flit, 32'h0);
    end
    start = 1'b0;
    tick();
    check_eq("drop_transmit", 32'(noc_if.o_transmit), 32'd0);
    check_eq("drop_sent", 32'(sent), 32'd0);
    tick(); tick();
    check_eq("drop_flit", noc_if.o_flit, 32'h0);

    // Sink checks, own address (0,0)
    do_reset();
    noc_if.i_flit = 32'hA000_0000;  // head to (0,0)
    tick();
    noc_if.i_flit = 32'hC000_0000;  // body
    tick();
    noc_if.i_flit = 32'hE000_0000;  // tail
    tick();
    noc_if.i_flit = 32'h0;
    tick();
    check_eq("sink_rcvd", 32'(rcvd), 32'd1);
    check_eq("sink_err_clean", 32'(err), 32'd0);
    noc_if.i_flit = 32'hC000_0000;  // body with no open packet
    tick();
    noc_if.i_flit = 32'h0;
    tick();
    check_eq("sink_err_frame", 32'(err), 32'd1);
    check_eq("sink_rcvd_keep", 32'(rcvd), 32'd1);
    noc_if.i_flit = 32'hB200_0000;  // head to (2,1)
    tick();
    noc_if.i_flit = 32'h0;
    tick();
    check_eq("sink_err_addr", 32'(err), 32'd3);

    // Reset on the second body cycle of a packet
    do_reset();
    mode = 2'd0; dx = 2'd3; dy = 2'd3;
    set_send(1'b1);
    start = 1'b1;
    wait_head("mid_first", f);
    wait_head("mid_second", f);
    check_eq("mid_sent_before", 32'(sent), 32'd1);
    tick();
    tick();
    check_eq("mid_body1", noc_if.o_flit, 32'hC000_0101);
    reset = 1'b1;
    tick();
    check_eq("mid_flit", noc_if.o_flit, 32'h0);
    check_eq("mid_sent", 32'(sent), 32'd0);
    check_eq("mid_transmit", 32'(noc_if.o_transmit), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_eq("mid_idle_transmit", 32'(noc_if.o_transmit), 32'd0);
    check_eq("mid_idle_flit", noc_if.o_flit, 32'h0);
    start = 1'b1;
    tick();
    check_eq("mid_restart", 32'(noc_if.o_transmit), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
